// File: rtl/lsu_mem_if.sv
// Load/store unit bridging the X stage to a single-port data memory with valid/ready wait states.
// Optional watchdog on the memory access is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsuState_t;

    lsuState_t   state, nextState;
    logic        weQ;
    logic [2:0]  funct3Q;
    logic [1:0]  laneQ;
    logic [4:0]  rdQ;
    logic [31:0] memAddrQ, memWdataQ, respRdataQ;
    logic [3:0]  memBeQ;
    logic [4:0]  respRdQ;
    logic        lsuErrQ;
    logic        reqLegal, reqAligned;
    logic        accept, reject, loadDone, timeoutHit;

    function automatic logic [3:0] storeBe(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   storeBe = 4'b0001 << lane;
            2'b01:   storeBe = lane[1] ? 4'b1100 : 4'b0011;
            default: storeBe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   storeData = {4{wdata[7:0]}};
            2'b01:   storeData = {2{wdata[15:0]}};
            default: storeData = wdata;
        endcase
    endfunction

    function automatic logic [31:0] loadExtend(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (f3)
            3'b000:  loadExtend = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  loadExtend = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  loadExtend = {24'd0, shifted[7:0]};
            3'b101:  loadExtend = {16'd0, shifted[15:0]};
            default: loadExtend = word;
        endcase
    endfunction

    always_comb begin
        case (req_funct3)
            3'b000, 3'b001, 3'b010: reqLegal = 1'b1;
            3'b100, 3'b101:         reqLegal = ~req_write;
            default:                reqLegal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   reqAligned = ~req_addr[0];
            2'b10:   reqAligned = (req_addr[1:0] == 2'b00);
            default: reqAligned = 1'b1;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] waitCnt;

    assign timeoutHit = (state == ACCESS) && !mem_ready && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside ACCESS, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || state != ACCESS) begin
            waitCnt <= '0;
        end else if (!mem_ready) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        loadDone  = 1'b0;
        case (state)
            IDLE, RESP: begin
                nextState = IDLE;
                if (req_valid) begin
                    if (reqLegal && reqAligned) begin
                        accept    = 1'b1;
                        stall     = 1'b1;
                        nextState = ACCESS;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall = ~mem_ready & ~timeoutHit;
                if (mem_ready) begin
                    loadDone  = ~weQ;
                    nextState = weQ ? IDLE : RESP;
                end else if (timeoutHit) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lsuErrQ    <= 1'b0;
            weQ        <= 1'b0;
            funct3Q    <= 3'd0;
            laneQ      <= 2'd0;
            rdQ        <= 5'd0;
            memAddrQ   <= 32'd0;
            memBeQ     <= 4'd0;
            memWdataQ  <= 32'd0;
            respRdataQ <= 32'd0;
            respRdQ    <= 5'd0;
        end else begin
            state   <= nextState;
            lsuErrQ <= reject | timeoutHit;
            if (accept) begin
                weQ       <= req_write;
                funct3Q   <= req_funct3;
                laneQ     <= req_addr[1:0];
                rdQ       <= req_rd;
                memAddrQ  <= {req_addr[31:2], 2'b00};
                memBeQ    <= req_write ? storeBe(req_funct3, req_addr[1:0]) : 4'b1111;
                memWdataQ <= storeData(req_funct3, req_wdata);
            end
            // Response registers only move on load completion so they hold between pulses.
            if (loadDone) begin
                respRdataQ <= loadExtend(funct3Q, laneQ, mem_rdata);
                respRdQ    <= rdQ;
            end
        end
    end

    assign mem_req    = (state == ACCESS);
    assign mem_we     = mem_req & weQ;
    assign mem_addr   = memAddrQ;
    assign mem_be     = memBeQ;
    assign mem_wdata  = memWdataQ;
    assign resp_valid = (state == RESP);
    assign resp_rdata = respRdataQ;
    assign resp_rd    = respRdQ;
    assign lsu_err    = lsuErrQ;

endmodule
